// File: rtl/mux_xbar_pkg.sv
// Shared helpers for the registered crossbar: index-width derivation and reset values.
package mux_xbar_pkg;

  // $clog2 returns 0 for counts of 1, but an index port still needs one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int sel_width(input int num_in);
    return clog2_min1(num_in);
  endfunction

  function automatic int out_width(input int num_out);
    return clog2_min1(num_out);
  endfunction

  localparam logic RST_VALID = 1'b0;
  localparam logic RST_OVF   = 1'b0;
  localparam logic RST_ERR   = 1'b0;

endpackage

// File: rtl/mux_xbar_reg_out_slot.sv
// One crossbar output: source-select register, 1-deep holding register with
// valid/ready handshake, and sticky overflow flag.
module xbar_out_slot
  import mux_xbar_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 8,
  parameter int SEL_W  = sel_width(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic                    cfg_wr,
  input  logic [SEL_W-1:0]        cfg_src,
  input  logic                    out_ready,
  input  logic                    ovf_clr,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic                    ovf
);

  logic [WIDTH-1:0] in_word [NUM_IN];
  logic [SEL_W-1:0] sel_d, sel_q;
  logic [WIDTH-1:0] data_d, data_q;
  logic             valid_d, valid_q;
  logic             ovf_d, ovf_q;
  logic             hit, space;

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_word
    assign in_word[gi] = in_data[gi*WIDTH +: WIDTH];
  end

  // Capture uses the registered select; a write this cycle only affects the next one.
  always_comb begin
    sel_d   = sel_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    hit     = en & in_valid[sel_q];
    space   = ~valid_q | out_ready;
    if (cfg_wr)
      sel_d = cfg_src;
    if (ovf_clr)
      ovf_d = 1'b0;
    if (hit && space) begin
      data_d  = in_word[sel_q];
      valid_d = 1'b1;
    end else if (hit) begin
      ovf_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q   <= '0;
      data_q  <= '0;
      valid_q <= RST_VALID;
      ovf_q   <= RST_OVF;
    end else begin
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign ovf       = ovf_q;

endmodule

// File: rtl/mux_xbar_reg.sv
// Registered NUM_IN x NUM_OUT crossbar: config decode and error pulse here,
// per-output routing and flow control in xbar_out_slot.
module mux_xbar_reg
  import mux_xbar_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NUM_IN  = 8,
  parameter int NUM_OUT = 2,
  parameter int SEL_W   = sel_width(NUM_IN),
  parameter int OUT_W   = out_width(NUM_OUT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NUM_IN*WIDTH-1:0]  in_data,
  input  logic [NUM_IN-1:0]        in_valid,
  input  logic                     cfg_we,
  input  logic [OUT_W-1:0]         cfg_out,
  input  logic [SEL_W-1:0]         cfg_src,
  output logic                     cfg_err,
  output logic [NUM_OUT*WIDTH-1:0] out_data,
  output logic [NUM_OUT-1:0]       out_valid,
  input  logic [NUM_OUT-1:0]       out_ready,
  output logic [NUM_OUT-1:0]       ovf,
  input  logic [NUM_OUT-1:0]       ovf_clr
);

  logic               cfg_legal;
  logic               cfg_err_d, cfg_err_q;
  logic [NUM_OUT-1:0] cfg_wr;

  // Index widths round up, so non-power-of-two counts leave unusable codes.
  always_comb begin
    cfg_legal = (32'(cfg_out) < NUM_OUT) && (32'(cfg_src) < NUM_IN);
    cfg_err_d = cfg_we & ~cfg_legal;
  end

  always_ff @(posedge clk) begin
    if (rst)
      cfg_err_q <= RST_ERR;
    else
      cfg_err_q <= cfg_err_d;
  end

  assign cfg_err = cfg_err_q;

  for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_slot
    assign cfg_wr[gi] = cfg_we & cfg_legal & (cfg_out == OUT_W'(gi));

    xbar_out_slot #(
      .WIDTH  (WIDTH),
      .NUM_IN (NUM_IN),
      .SEL_W  (SEL_W)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .cfg_wr    (cfg_wr[gi]),
      .cfg_src   (cfg_src),
      .out_ready (out_ready[gi]),
      .ovf_clr   (ovf_clr[gi]),
      .out_data  (out_data[gi*WIDTH +: WIDTH]),
      .out_valid (out_valid[gi]),
      .ovf       (ovf[gi])
    );
  end

endmodule

// File: tb/tb_mux_xbar_reg.sv
// Directed bench for mux_xbar_reg: expectations queued at drive time, checked
// 1 time unit after the next rising edge.
module tb_mux_xbar_reg;

  localparam int K_DATA  = 0;
  localparam int K_VALID = 1;
  localparam int K_OVF   = 2;
  localparam int K_ERR   = 3;

  typedef struct {
    string       tag;
    int          dut;
    int          kind;
    int          idx;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_step = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: WIDTH=8, NUM_IN=6, NUM_OUT=2
  logic        a_rst, a_en, a_cfg_we, a_cfg_err;
  logic [47:0] a_in_data;
  logic [5:0]  a_in_valid;
  logic [0:0]  a_cfg_out;
  logic [2:0]  a_cfg_src;
  logic [15:0] a_out_data;
  logic [1:0]  a_out_valid, a_out_ready, a_ovf, a_ovf_clr;

  // DUT B: WIDTH=16, NUM_IN=4, NUM_OUT=4
  logic        b_rst, b_en, b_cfg_we, b_cfg_err;
  logic [63:0] b_in_data;
  logic [3:0]  b_in_valid;
  logic [1:0]  b_cfg_out;
  logic [1:0]  b_cfg_src;
  logic [63:0] b_out_data;
  logic [3:0]  b_out_valid, b_out_ready, b_ovf, b_ovf_clr;

  mux_xbar_reg #(.WIDTH(8), .NUM_IN(6), .NUM_OUT(2)) u_a (
    .clk(clk), .rst(a_rst), .en(a_en), .in_data(a_in_data), .in_valid(a_in_valid),
    .cfg_we(a_cfg_we), .cfg_out(a_cfg_out), .cfg_src(a_cfg_src), .cfg_err(a_cfg_err),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .ovf(a_ovf), .ovf_clr(a_ovf_clr)
  );

  mux_xbar_reg #(.WIDTH(16), .NUM_IN(4), .NUM_OUT(4)) u_b (
    .clk(clk), .rst(b_rst), .en(b_en), .in_data(b_in_data), .in_valid(b_in_valid),
    .cfg_we(b_cfg_we), .cfg_out(b_cfg_out), .cfg_src(b_cfg_src), .cfg_err(b_cfg_err),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .ovf(b_ovf), .ovf_clr(b_ovf_clr)
  );

  function automatic logic [15:0] obs(input int dut, input int kind, input int idx);
    if (dut == 0) begin
      case (kind)
        K_DATA:  return {8'h00, a_out_data[idx*8 +: 8]};
        K_VALID: return {15'h0, a_out_valid[idx]};
        K_OVF:   return {15'h0, a_ovf[idx]};
        default: return {15'h0, a_cfg_err};
      endcase
    end else begin
      case (kind)
        K_DATA:  return b_out_data[idx*16 +: 16];
        K_VALID: return {15'h0, b_out_valid[idx]};
        K_OVF:   return {15'h0, b_ovf[idx]};
        default: return {15'h0, b_cfg_err};
      endcase
    end
  endfunction

  task automatic ex(input string tag, input int dut, input int kind, input int idx,
                    input logic [15:0] v);
    exp_t e;
    e.tag = tag; e.dut = dut; e.kind = kind; e.idx = idx; e.val = v;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t        e;
    logic [15:0] o;
    int          n;
    @(posedge clk);
    #1;
    n = sb.size();
    n_step++;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.dut, e.kind, e.idx);
      n_cmp++;
      assert (o === e.val)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, o, e.val);
      end
    end
    $display("step %0d: %0d checks", n_step, n);
  endtask

  initial begin
    a_rst = 1; a_en = 0; a_cfg_we = 0; a_cfg_out = 0; a_cfg_src = 0;
    a_in_data = '0; a_in_valid = '0; a_out_ready = '0; a_ovf_clr = '0;
    b_rst = 1; b_en = 0; b_cfg_we = 0; b_cfg_out = 0; b_cfg_src = 0;
    b_in_data = '0; b_in_valid = '0; b_out_ready = '0; b_ovf_clr = '0;

    // reset state
    tick();
    ex("rst_err", 0, K_ERR, 0, 0);
    for (int o = 0; o < 2; o++) begin
      ex("rst_valid", 0, K_VALID, o, 0);
      ex("rst_ovf", 0, K_OVF, o, 0);
      ex("rst_data", 0, K_DATA, o, 0);
    end
    tick();

    // 1: route sel[1]=3
    a_rst = 0; a_en = 1; a_out_ready = 2'b11;
    a_cfg_we = 1; a_cfg_out = 1; a_cfg_src = 3;
    ex("cfg_ok_err", 0, K_ERR, 0, 0);
    tick();
    a_cfg_we = 0; a_in_data[3*8 +: 8] = 8'h5A; a_in_valid = 6'b001000;
    ex("route_data1", 0, K_DATA, 1, 16'h5A);
    ex("route_valid1", 0, K_VALID, 1, 1);
    ex("route_valid0", 0, K_VALID, 0, 0);
    tick();
    a_in_data[0 +: 8] = 8'h33; a_in_valid = 6'b000001;
    ex("route_data0", 0, K_DATA, 0, 16'h33);
    ex("route_valid0b", 0, K_VALID, 0, 1);
    ex("drain_valid1", 0, K_VALID, 1, 0);
    ex("drain_hold1", 0, K_DATA, 1, 16'h5A);
    tick();
    a_in_valid = '0;
    ex("drain_valid0", 0, K_VALID, 0, 0);
    ex("drain_hold0", 0, K_DATA, 0, 16'h33);
    tick();

    // 2: backpressure / overflow
    a_out_ready = 2'b10; a_in_data[0 +: 8] = 8'h11; a_in_valid = 6'b000001;
    ex("bp_first", 0, K_DATA, 0, 16'h11);
    ex("bp_valid", 0, K_VALID, 0, 1);
    tick();
    a_in_data[0 +: 8] = 8'h22;
    ex("bp_hold", 0, K_DATA, 0, 16'h11);
    ex("bp_ovf_set", 0, K_OVF, 0, 1);
    ex("bp_ovf_other", 0, K_OVF, 1, 0);
    tick();
    a_in_valid = '0; a_ovf_clr = 2'b01;
    ex("ovf_clear", 0, K_OVF, 0, 0);
    ex("bp_still_valid", 0, K_VALID, 0, 1);
    tick();
    a_ovf_clr = 0; a_out_ready = 2'b11; a_in_valid = 6'b000001;
    ex("bp_release", 0, K_DATA, 0, 16'h22);
    ex("bp_release_ovf", 0, K_OVF, 0, 0);
    tick();
    a_out_ready = 2'b10; a_ovf_clr = 2'b01;
    ex("ovf_set_wins", 0, K_OVF, 0, 1);
    tick();
    a_out_ready = 2'b11; a_in_valid = '0;
    ex("ovf_clr2", 0, K_OVF, 0, 0);
    ex("bp_drain", 0, K_VALID, 0, 0);
    tick();
    a_ovf_clr = 0;

    // 3: streaming from input 2
    a_cfg_we = 1; a_cfg_out = 0; a_cfg_src = 2;
    tick();
    a_cfg_we = 0; a_in_valid = 6'b000100;
    for (int k = 1; k <= 4; k++) begin
      a_in_data[2*8 +: 8] = 8'(k);
      ex("stream_data", 0, K_DATA, 0, 16'(k));
      ex("stream_valid", 0, K_VALID, 0, 1);
      tick();
    end
    a_in_valid = '0;
    ex("stream_end", 0, K_VALID, 0, 0);
    ex("stream_hold", 0, K_DATA, 0, 16'h04);
    tick();

    // 4: config/capture collision
    a_cfg_we = 1; a_cfg_out = 0; a_cfg_src = 1;
    tick();
    a_cfg_src = 4; a_in_data[1*8 +: 8] = 8'hAA; a_in_data[4*8 +: 8] = 8'hBB;
    a_in_valid = 6'b010010;
    ex("coll_old_sel", 0, K_DATA, 0, 16'hAA);
    tick();
    a_cfg_we = 0;
    ex("coll_new_sel", 0, K_DATA, 0, 16'hBB);
    ex("coll_valid", 0, K_VALID, 0, 1);
    tick();
    a_in_valid = '0;
    tick();

    // 5: illegal config and en=0
    a_cfg_we = 1; a_cfg_out = 0; a_cfg_src = 7;
    ex("ill_err7", 0, K_ERR, 0, 1);
    tick();
    a_cfg_src = 6;
    ex("ill_err6", 0, K_ERR, 0, 1);
    tick();
    a_cfg_we = 0; a_in_data[4*8 +: 8] = 8'hCC; a_in_valid = 6'b010000;
    ex("ill_err_pulse", 0, K_ERR, 0, 0);
    ex("ill_sel_kept", 0, K_DATA, 0, 16'hCC);
    tick();
    a_in_valid = '0;
    tick();
    a_out_ready = 2'b00; a_in_data[4*8 +: 8] = 8'h77; a_in_valid = 6'b010000;
    ex("en_cap", 0, K_DATA, 0, 16'h77);
    tick();
    a_en = 0; a_in_data[4*8 +: 8] = 8'h78;
    ex("en0_no_cap", 0, K_DATA, 0, 16'h77);
    ex("en0_no_ovf", 0, K_OVF, 0, 0);
    ex("en0_valid", 0, K_VALID, 0, 1);
    tick();
    a_out_ready = 2'b11; a_in_valid = 6'b111111;
    ex("en0_drain", 0, K_VALID, 0, 0);
    ex("en0_drain_data", 0, K_DATA, 0, 16'h77);
    tick();
    a_out_ready = 2'b00;
    ex("en0_idle_v0", 0, K_VALID, 0, 0);
    ex("en0_idle_v1", 0, K_VALID, 1, 0);
    ex("en0_idle_ovf1", 0, K_OVF, 1, 0);
    tick();

    // 6: reset mid-operation
    a_en = 1; a_in_data[3*8 +: 8] = 8'h99; a_in_data[4*8 +: 8] = 8'h88;
    a_in_valid = 6'b011000;
    ex("pre_rst_v0", 0, K_VALID, 0, 1);
    ex("pre_rst_v1", 0, K_VALID, 1, 1);
    ex("pre_rst_d1", 0, K_DATA, 1, 16'h99);
    tick();
    a_in_valid = 6'b010000;
    ex("pre_rst_ovf0", 0, K_OVF, 0, 1);
    ex("pre_rst_ovf1", 0, K_OVF, 1, 0);
    tick();
    a_rst = 1; a_cfg_we = 1; a_cfg_src = 7; a_in_valid = 6'b111111;
    a_out_ready = 2'b11;
    ex("mid_rst_err", 0, K_ERR, 0, 0);
    for (int o = 0; o < 2; o++) begin
      ex("mid_rst_valid", 0, K_VALID, o, 0);
      ex("mid_rst_ovf", 0, K_OVF, o, 0);
      ex("mid_rst_data", 0, K_DATA, o, 0);
    end
    tick();
    a_rst = 0; a_cfg_we = 0; a_in_data[0 +: 8] = 8'h44; a_in_valid = 6'b000001;
    ex("rst_sel0", 0, K_DATA, 0, 16'h44);
    ex("rst_sel1", 0, K_DATA, 1, 16'h44);
    tick();

    // parameter sweep: WIDTH=16, NUM_IN=4, NUM_OUT=4
    for (int o = 0; o < 4; o++) begin
      ex("b_rst_valid", 1, K_VALID, o, 0);
      ex("b_rst_data", 1, K_DATA, o, 0);
    end
    tick();
    b_rst = 0; b_en = 1; b_out_ready = 4'hF;
    b_cfg_we = 1; b_cfg_out = 3; b_cfg_src = 2;
    ex("b_cfg_err", 1, K_ERR, 0, 0);
    tick();
    b_cfg_we = 0; b_in_data[2*16 +: 16] = 16'hBEEF; b_in_valid = 4'b0100;
    ex("b_route_d3", 1, K_DATA, 3, 16'hBEEF);
    ex("b_route_v3", 1, K_VALID, 3, 1);
    ex("b_route_v0", 1, K_VALID, 0, 0);
    tick();
    b_in_valid = '0;
    for (int o = 0; o < 4; o++) begin
      b_cfg_we = 1; b_cfg_out = 2'(o); b_cfg_src = 1;
      tick();
    end
    b_cfg_we = 0; b_in_data[1*16 +: 16] = 16'h1234; b_in_valid = 4'b0010;
    for (int o = 0; o < 4; o++) begin
      ex("b_bcast_data", 1, K_DATA, o, 16'h1234);
      ex("b_bcast_valid", 1, K_VALID, o, 1);
    end
    tick();
    b_out_ready = 4'b0101; b_in_data[1*16 +: 16] = 16'h5678;
    for (int o = 0; o < 4; o++) begin
      ex("b_bp_data", 1, K_DATA, o, (o % 2 == 0) ? 16'h5678 : 16'h1234);
      ex("b_bp_ovf", 1, K_OVF, o, (o % 2 == 0) ? 16'h0 : 16'h1);
    end
    tick();
    b_out_ready = 4'hF; b_ovf_clr = 4'hF;
    for (int k = 1; k <= 3; k++) begin
      b_in_data[1*16 +: 16] = 16'h1000 + 16'(k);
      ex("b_stream_d0", 1, K_DATA, 0, 16'h1000 + 16'(k));
      ex("b_stream_d3", 1, K_DATA, 3, 16'h1000 + 16'(k));
      ex("b_stream_v1", 1, K_VALID, 1, 1);
      if (k == 1) ex("b_stream_ovf1", 1, K_OVF, 1, 0);
      tick();
      b_ovf_clr = '0;
    end
    b_in_valid = '0;
    ex("b_stream_end", 1, K_VALID, 2, 0);
    ex("b_stream_hold", 1, K_DATA, 2, 16'h1003);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
